// File: rtl/systolic_quantize.sv
// Drain-side quantizer: round-half-up shift and saturate one accumulator
// anti-diagonal per beat, framed by an IDLE/DRAIN sequencer for SRAM write-out.
module systolic_quantize #(
  parameter int ARRAY_SIZE        = 16,
  parameter int ACC_WIDTH         = 40,
  parameter int OUTPUT_DATA_WIDTH = 24,
  parameter int SHIFT             = 8
) (
  input  logic                                      clk,
  input  logic                                      srstn,
  input  logic                                      start,
  input  logic [1:0]                                set_sel,
  input  logic                                      acc_valid,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]           acc_data,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      sram_write_enable,
  output logic [1:0]                                data_set,
  output logic [5:0]                                matrix_index,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   quantized_data,
  output logic                                      sat_flag
);

  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam logic [5:0] LAST_IDX = 6'(2*ARRAY_SIZE-2);
  localparam logic signed [ACC_WIDTH:0] RND =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [ACC_WIDTH:0] Q_MAX =
    {{(ACC_WIDTH-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] Q_MIN =
    {{(ACC_WIDTH-OW+2){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1
  } state_t;

  state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [1:0] set_nxt;
  logic       vld_p0, last_p0;

  logic signed [ACC_WIDTH:0]              r_p0;
  logic [ARRAY_SIZE*OW-1:0]               q_p0;
  logic                                   sat_p0;

  logic                                   vld_p1, done_p1, sat_p1;
  logic [5:0]                             idx_p1;
  logic [ARRAY_SIZE*OW-1:0]               q_p1;

  // Extra headroom bit keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] acc
  );
    logic signed [ACC_WIDTH:0] t;
    t = {acc[ACC_WIDTH-1], acc} + RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [OW-1:0] saturate(
    input logic signed [ACC_WIDTH:0] r
  );
    if (r > Q_MAX)      return Q_MAX[OW-1:0];
    else if (r < Q_MIN) return Q_MIN[OW-1:0];
    else                return r[OW-1:0];
  endfunction

  function automatic logic is_clamped(input logic signed [ACC_WIDTH:0] r);
    return (r > Q_MAX) || (r < Q_MIN);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    set_nxt   = data_set;
    vld_p0    = 1'b0;
    last_p0   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRAIN;
          cnt_nxt   = 6'd0;
          set_nxt   = set_sel;
        end
      end
      DRAIN: begin
        if (acc_valid) begin
          vld_p0  = 1'b1;
          cnt_nxt = cnt + 6'd1;
          if (cnt == LAST_IDX) begin
            last_p0   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r_p0   = '0;
    q_p0   = '0;
    sat_p0 = 1'b0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      r_p0 = round_shift(acc_data[i*ACC_WIDTH +: ACC_WIDTH]);
      q_p0[i*OW +: OW] = saturate(r_p0);
      sat_p0 = sat_p0 | is_clamped(r_p0);
    end
  end

  // p0 -> p1: control registers
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      data_set <= 2'd0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      idx_p1   <= 6'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data_set <= set_nxt;
      vld_p1   <= vld_p0;
      done_p1  <= last_p0;
      if (vld_p0) idx_p1 <= cnt;
    end
  end

  // p0 -> p1: lane data, forced to zero on any cycle without an accepted beat
  always_ff @(posedge clk) begin
    q_p1   <= (srstn && vld_p0) ? q_p0 : '0;
    sat_p1 <= srstn && vld_p0 && sat_p0;
  end

  assign busy              = (state == DRAIN);
  assign done              = done_p1;
  assign sram_write_enable = vld_p1;
  assign matrix_index      = idx_p1;
  assign quantized_data    = q_p1;
  assign sat_flag          = sat_p1;

endmodule

// File: tb/tb_systolic_quantize.sv
// Bench for systolic_quantize: table-driven rounding/saturation vectors plus
// drain sequences, checked through an expected-write scoreboard.
module tb_systolic_quantize;

  localparam int N  = 16;
  localparam int AW = 40;
  localparam int OW = 24;

  logic               clk;
  logic               srstn;
  logic               start;
  logic [1:0]         set_sel;
  logic               acc_valid;
  logic [N*AW-1:0]    acc_data;
  logic               busy, done, sram_write_enable, sat_flag;
  logic [1:0]         data_set;
  logic [5:0]         matrix_index;
  logic [N*OW-1:0]    quantized_data;

  systolic_quantize #(
    .ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUTPUT_DATA_WIDTH(OW), .SHIFT(8)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start), .set_sel(set_sel),
    .acc_valid(acc_valid), .acc_data(acc_data), .busy(busy), .done(done),
    .sram_write_enable(sram_write_enable), .data_set(data_set),
    .matrix_index(matrix_index), .quantized_data(quantized_data),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      idx;
    logic [N*OW-1:0] q;
    logic            sat;
    logic            dn;
    logic [1:0]      set;
  } exp_t;

  typedef struct {
    logic signed [AW-1:0] acc;
    logic signed [OW-1:0] q;
    logic                 sat;
  } vec_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t tbl[15];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [N*OW-1:0] act, input logic [N*OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) busy_cnt++;
      if (sram_write_enable === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: index %0d with nothing expected", matrix_index);
        end else begin
          e_mon = sb.pop_front();
          chk("matrix_index", matrix_index, e_mon.idx);
          chk("quantized_data", quantized_data, e_mon.q);
          chk("sat_flag", sat_flag, e_mon.sat);
          chk("done", done, e_mon.dn);
          chk("data_set", data_set, e_mon.set);
        end
      end else begin
        chk("idle_qdata", quantized_data, '0);
        chk("idle_done", done, '0);
        chk("idle_sat", sat_flag, '0);
      end
    end
  end

  task automatic beat(input logic [N*AW-1:0] d, input logic [N*OW-1:0] q, input logic s,
                      input logic [5:0] idx, input logic dn, input logic [1:0] set);
    exp_t e;
    e.idx = idx; e.q = q; e.sat = s; e.dn = dn; e.set = set;
    sb.push_back(e);
    acc_valid = 1'b1;
    acc_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    acc_valid = 1'b0;
    acc_data  = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_drain(input logic [1:0] set);
    acc_valid = 1'b0;
    start     = 1'b1;
    set_sel   = set;
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic flush();
    for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge clk);
    #1 chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*AW-1:0] d;
    logic [N*OW-1:0] q;

    tbl[0]  = '{40'sd383, 24'sd1, 1'b0};
    tbl[1]  = '{40'sd384, 24'sd2, 1'b0};
    tbl[2]  = '{-40'sd384, -24'sd1, 1'b0};
    tbl[3]  = '{-40'sd385, -24'sd2, 1'b0};
    tbl[4]  = '{40'sd0, 24'sd0, 1'b0};
    tbl[5]  = '{40'sd127, 24'sd0, 1'b0};
    tbl[6]  = '{40'sd128, 24'sd1, 1'b0};
    tbl[7]  = '{-40'sd128, 24'sd0, 1'b0};
    tbl[8]  = '{-40'sd129, -24'sd1, 1'b0};
    tbl[9]  = '{40'sh7F_FFFF_FFFF, 24'sh7FFFFF, 1'b1};
    tbl[10] = '{40'sh80_0000_0000, 24'sh800000, 1'b1};
    tbl[11] = '{40'sd2147483519, 24'sh7FFFFF, 1'b0};
    tbl[12] = '{40'sd2147483520, 24'sh7FFFFF, 1'b1};
    tbl[13] = '{-40'sd2147483776, 24'sh800000, 1'b0};
    tbl[14] = '{-40'sd2147483777, 24'sh800000, 1'b1};

    // Reset with start/acc_valid asserted: everything must stay quiet.
    srstn = 1'b0; start = 1'b1; set_sel = 2'd1; acc_valid = 1'b1;
    acc_data = {(N*AW/8){8'hA5}};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", sram_write_enable, 1'b0);
    chk("rst_set", data_set, 2'd0);
    chk("rst_idx", matrix_index, 6'd0);
    chk("rst_qdata", quantized_data, '0);
    chk("rst_sat", sat_flag, 1'b0);
    srstn = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0;
    @(negedge clk);
    mon_en = 1'b1;

    // Full contiguous drain, lane i = (i+1)*256.
    for (int i = 0; i < N; i++) begin
      d[i*AW +: AW] = 40'((i+1)*256);
      q[i*OW +: OW] = 24'(i+1);
    end
    busy_cnt = 0;
    start_drain(2'd1);
    for (int b = 0; b < 31; b++) beat(d, q, 1'b0, 6'(b), b == 30, 2'd1);
    #1 chk("busy_in_done_cycle", busy, 1'b0);
    idle(1);
    flush();
    chk("busy_cycles", busy_cnt, 31);

    // Gapped drain with an ignored start pulse mid-way.
    for (int i = 0; i < N; i++) begin
      d[i*AW +: AW] = 40'(-(i+1)*256 - 128);
      q[i*OW +: OW] = 24'(-(i+1));
    end
    start_drain(2'd1);
    for (int b = 0; b < 31; b++) begin
      beat(d, q, 1'b0, 6'(b), b == 30, 2'd1);
      if (b == 5) begin
        acc_valid = 1'b0; start = 1'b1; set_sel = 2'd0;
        @(negedge clk);
        start = 1'b0;
        #1 chk("busy_after_ignored_start", busy, 1'b1);
        idle(1);
      end else if (b < 30) begin
        idle(2);
      end
    end
    idle(1);
    flush();

    // Reset after beat 10, with a live beat and start held during reset.
    for (int i = 0; i < N; i++) begin
      d[i*AW +: AW] = 40'((i+1)*256);
      q[i*OW +: OW] = 24'(i+1);
    end
    start_drain(2'd1);
    for (int b = 0; b <= 10; b++) beat(d, q, 1'b0, 6'(b), 1'b0, 2'd1);
    srstn = 1'b0; start = 1'b1; acc_valid = 1'b1; acc_data = d;
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_we", sram_write_enable, 1'b0);
    chk("midrst_set", data_set, 2'd0);
    chk("midrst_idx", matrix_index, 6'd0);
    chk("midrst_qdata", quantized_data, '0);
    chk("midrst_sat", sat_flag, 1'b0);
    srstn = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0;
    @(negedge clk);
    #1 chk("idle_after_reset", busy, 1'b0);
    flush();

    // Restart with set 0: rounding/saturation table on lanes 0 and 15.
    start_drain(2'd0);
    for (int b = 0; b < 31; b++) begin
      d = '0;
      q = '0;
      if (b < 15) begin
        d[0 +: AW] = tbl[b].acc;
        d[(N-1)*AW +: AW] = tbl[b].acc;
        q[0 +: OW] = tbl[b].q;
        q[(N-1)*OW +: OW] = tbl[b].q;
        beat(d, q, tbl[b].sat, 6'(b), 1'b0, 2'd0);
      end else begin
        beat(d, q, 1'b0, 6'(b), b == 30, 2'd0);
      end
    end
    #1 chk("busy_in_done_cycle2", busy, 1'b0);

    // Back-to-back: start during the done cycle, saturating drain.
    for (int i = 0; i < N; i++) begin
      d[i*AW +: AW] = (i % 2 == 0) ? 40'h7F_FFFF_FFFF : 40'h80_0000_0000;
      q[i*OW +: OW] = (i % 2 == 0) ? 24'h7FFFFF : 24'h800000;
    end
    start_drain(2'd1);
    for (int b = 0; b < 31; b++) beat(d, q, 1'b1, 6'(b), b == 30, 2'd1);
    idle(2);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
